// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling window sequencer.
// Imported by pool_lane_gen and pool_window_ctrl.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam int LANES   = 4;
  localparam int LANE_TL = 0;
  localparam int LANE_TR = 1;
  localparam int LANE_BL = 2;
  localparam int LANE_BR = 3;

  localparam int P_ADDR_W = 8;

  // All-ones address of width w marks a lane outside the map
  function automatic logic [31:0] null_addr(input int w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  typedef struct packed {
    logic [LANES-1:0][P_ADDR_W-1:0] addr;
    logic [LANES-1:0]               lane_valid;
    logic                           last;
  } win_t;

endpackage

// File: rtl/pool_lane_gen.sv
// Maps a window origin (row base, r, c) to four lane addresses.
// Lanes past the map edge read NULL and are flagged invalid.
module pool_lane_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 4
) (
  input  logic [ADDR_W-1:0]             row_base,
  input  logic [DIM_W-1:0]              r,
  input  logic [DIM_W-1:0]              c,
  input  logic [DIM_W-1:0]              dim,
  output logic [LANES-1:0][ADDR_W-1:0]  addr,
  output logic [LANES-1:0]              lane_valid
);

  localparam logic [ADDR_W-1:0] NULL_A =
    ADDR_W'(null_addr(ADDR_W));
  localparam logic [DIM_W:0] ONE = 1;

  logic [ADDR_W-1:0] top_a;
  logic [ADDR_W-1:0] bot_a;
  logic              col_ok;
  logic              row_ok;

  // Lane addresses from the running row base, adders only
  always_comb begin
    col_ok = ({1'b0, c} + ONE) < {1'b0, dim};
    row_ok = ({1'b0, r} + ONE) < {1'b0, dim};
    top_a  = row_base + ADDR_W'(c);
    bot_a  = top_a + ADDR_W'(dim);
    lane_valid          = '0;
    lane_valid[LANE_TL] = 1'b1;
    lane_valid[LANE_TR] = col_ok;
    lane_valid[LANE_BL] = row_ok;
    lane_valid[LANE_BR] = col_ok & row_ok;
    addr          = '0;
    addr[LANE_TL] = top_a;
    addr[LANE_TR] = col_ok ? top_a + ADDR_W'(1) : NULL_A;
    addr[LANE_BL] = row_ok ? bot_a : NULL_A;
    addr[LANE_BR] = (col_ok & row_ok) ?
                    bot_a + ADDR_W'(1) : NULL_A;
  end

endmodule

// File: rtl/pool_window_ctrl.sv
// 2x2 stride-2 pooling address sequencer: FSM, counters and
// registered window output with valid/ready handshake.
module pool_window_ctrl
  import pool_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DIM_W   = 4,
  parameter int MAX_DIM = 15,
  parameter int CH_W    = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [DIM_W-1:0]              dim,
  input  logic [CH_W-1:0]               num_ch,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [LANES-1:0][ADDR_W-1:0]  win_addr,
  output logic [LANES-1:0]              lane_valid,
  output logic                          win_last,
  output logic                          max_avg,
  output logic                          in_pipe_en,
  output logic                          out_pipe_en
);

  localparam logic [ADDR_W-1:0] NULL_A =
    ADDR_W'(null_addr(ADDR_W));
  localparam logic [DIM_W:0] TWO  = 2;
  localparam logic [DIM_W:0] MAXD = (DIM_W+1)'(MAX_DIM);

  state_t            state, state_n;
  logic              mode_q, err_q;
  logic [DIM_W-1:0]  dim_q;
  logic [CH_W-1:0]   nch_q;
  logic [ADDR_W-1:0] base_q, stride_q;
  logic [DIM_W-1:0]  r_q, c_q, r_n, c_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] ch_base, ch_base_n;
  logic              load_win, clr_win, bad;
  logic              c_wrap, r_wrap, last_n;
  logic [2*DIM_W-1:0] dim_w;
  logic [LANES-1:0][ADDR_W-1:0] g_addr;
  logic [LANES-1:0]             g_valid;

  pool_lane_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_lane_gen (
    .row_base   (row_base_n),
    .r          (r_n),
    .c          (c_n),
    .dim        (dim_q),
    .addr       (g_addr),
    .lane_valid (g_valid)
  );

  assign win_valid  = (state == S_ISSUE);
  assign busy       = (state == S_CHECK) | win_valid;
  assign done       = (state == S_DONE);
  assign err        = done & err_q;
  assign in_pipe_en = win_valid & win_ready;
  assign max_avg    = mode_q;
  assign dim_w      = (2*DIM_W)'(dim_q);

  // Next state and next window position
  always_comb begin
    state_n    = state;
    r_n        = r_q;
    c_n        = c_q;
    ch_n       = ch_q;
    row_base_n = row_base;
    ch_base_n  = ch_base;
    load_win   = 1'b0;
    clr_win    = 1'b0;
    bad    = ({1'b0, dim_q} < TWO) ||
             ({1'b0, dim_q} > MAXD) ||
             (nch_q == '0);
    c_wrap = ({1'b0, c_q} + TWO) >= {1'b0, dim_q};
    r_wrap = ({1'b0, r_q} + TWO) >= {1'b0, dim_q};
    unique case (state)
      S_IDLE: if (start) state_n = S_CHECK;
      S_CHECK: begin
        if (bad) begin
          state_n = S_DONE;
        end else begin
          state_n    = S_ISSUE;
          r_n        = '0;
          c_n        = '0;
          ch_n       = '0;
          row_base_n = base_q;
          ch_base_n  = base_q;
          load_win   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (in_pipe_en && win_last) begin
          state_n = S_DONE;
          clr_win = 1'b1;
        end else if (in_pipe_en) begin
          load_win = 1'b1;
          if (!c_wrap) begin
            c_n = c_q + DIM_W'(2);
          end else begin
            c_n = '0;
            if (!r_wrap) begin
              r_n        = r_q + DIM_W'(2);
              row_base_n = row_base +
                           ADDR_W'({dim_q, 1'b0});
            end else begin
              r_n        = '0;
              ch_n       = ch_q + CH_W'(1);
              ch_base_n  = ch_base + stride_q;
              row_base_n = ch_base + stride_q;
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    last_n = (({1'b0, r_n} + TWO) >= {1'b0, dim_q}) &&
             (({1'b0, c_n} + TWO) >= {1'b0, dim_q}) &&
             (ch_n == nch_q - CH_W'(1));
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Config latch, error flag and channel stride
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q   <= 1'b1;
      dim_q    <= '0;
      nch_q    <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
      stride_q <= '0;
    end else if (state == S_IDLE && start) begin
      mode_q <= mode;
      dim_q  <= dim;
      nch_q  <= num_ch;
      base_q <= base_addr;
    end else if (state == S_CHECK) begin
      err_q    <= bad;
      stride_q <= ADDR_W'(dim_w * dim_w);
    end
  end

  // Window position counters and running bases
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_q      <= '0;
      c_q      <= '0;
      ch_q     <= '0;
      row_base <= '0;
      ch_base  <= '0;
    end else begin
      r_q      <= r_n;
      c_q      <= c_n;
      ch_q     <= ch_n;
      row_base <= row_base_n;
      ch_base  <= ch_base_n;
    end
  end

  // Registered window outputs, held while stalled
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      win_addr   <= {LANES{NULL_A}};
      lane_valid <= '0;
      win_last   <= 1'b0;
    end else if (load_win) begin
      win_addr   <= g_addr;
      lane_valid <= g_valid;
      win_last   <= last_n;
    end else if (clr_win) begin
      win_addr   <= {LANES{NULL_A}};
      lane_valid <= '0;
      win_last   <= 1'b0;
    end
  end

  // PU result stage trails the load stage by one cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) out_pipe_en <= 1'b0;
    else       out_pipe_en <= in_pipe_en;
  end

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl: config table, random configs
// against a loop-based window model, reset and stall sequences.
module tb_pool_window_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  dim = '0;
  logic [3:0]  num_ch = '0;
  logic [7:0]  base_addr = '0;
  logic        win_ready = 1'b0;
  logic        busy, done, err, win_valid, win_last;
  logic        max_avg, in_pipe_en, out_pipe_en;
  logic [3:0][7:0] win_addr;
  logic [3:0]  lane_valid;

  pool_window_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .mode        (mode),
    .dim         (dim),
    .num_ch      (num_ch),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_addr    (win_addr),
    .lane_valid  (lane_valid),
    .win_last    (win_last),
    .max_avg     (max_avg),
    .in_pipe_en  (in_pipe_en),
    .out_pipe_en (out_pipe_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0][7:0] addr;
    logic [3:0]      lv;
    bit              last;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int d;
    int n;
    int b;
    bit m;
    int rdy;
    bit err;
    int nwin;
  } vec_t;

  task automatic check(input string name,
                       input longint act,
                       input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  name, act, req);
  endtask

  // Expected windows straight from the map geometry
  task automatic build_model(input int d, input int n,
                             input int b);
    exp_t e;
    exp_q.delete();
    if (d < 2 || d > 15 || n == 0) return;
    for (int ch = 0; ch < n; ch++)
      for (int r = 0; r < d; r += 2)
        for (int c = 0; c < d; c += 2) begin
          for (int i = 0; i < 4; i++) begin
            int rr = r + i / 2;
            int cc = c + i % 2;
            if (rr < d && cc < d) begin
              e.addr[i] = 8'((b + ch*d*d + rr*d + cc) % 256);
              e.lv[i]   = 1'b1;
            end else begin
              e.addr[i] = 8'hFF;
              e.lv[i]   = 1'b0;
            end
          end
          e.last = (ch == n-1) && (r+2 >= d) && (c+2 >= d);
          exp_q.push_back(e);
        end
  endtask

  task automatic run_cfg(input int d, input int n, input int b,
                         input bit m, input int rdy,
                         input bit exp_err, input int exp_nwin,
                         input bit poke);
    int cyc = 0;
    int nwin = 0;
    int last_hs = -1;
    int stall = 0;
    bit fin = 0;
    bit prev_in = 0;
    bit prev_stall = 0;
    logic [3:0][7:0] prev_addr = '0;
    logic [3:0] prev_lv = '0;
    exp_t e;
    build_model(d, n, b);
    @(negedge clk);
    dim = 4'(d); num_ch = 4'(n); base_addr = 8'(b);
    mode = m; start = 1'b1; win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (!fin && cyc < 3000) begin
      start = 1'b0;
      if (rdy < 0) win_ready = !(nwin == 1 && stall < 3);
      else if (rdy >= 100) win_ready = 1'b1;
      else win_ready = ($urandom_range(99) < rdy);
      #1;
      if (done) begin
        fin = 1;
        check("err", err, exp_err);
        check("busy_at_done", busy, 0);
        if (exp_err) check("err_latency", cyc, 1);
        else check("done_latency", cyc, last_hs + 1);
        check("window_count", nwin, exp_nwin);
        check("model_left", exp_q.size(), 0);
      end else begin
        check("out_pipe_en", out_pipe_en, prev_in);
        if (win_valid) begin
          if (exp_err) check("valid_on_err", 1, 0);
          check("in_pipe_en", in_pipe_en, win_ready);
          check("max_avg", max_avg, m);
          if (prev_stall) begin
            check("stall_addr", win_addr, prev_addr);
            check("stall_lv", lane_valid, prev_lv);
          end
          if (win_ready) begin
            if (exp_q.size() == 0) begin
              check("extra_window", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("win_addr", win_addr, e.addr);
              check("lane_valid", lane_valid, e.lv);
              check("win_last", win_last, e.last);
            end
            nwin++;
            last_hs = cyc;
          end else if (rdy < 0) begin
            stall++;
          end
          prev_stall = !win_ready;
          prev_addr  = win_addr;
          prev_lv    = lane_valid;
        end else begin
          prev_stall = 0;
        end
        if (poke && cyc == 3) begin
          start = 1'b1;
          dim = 4'($urandom_range(2, 15));
          num_ch = 4'($urandom_range(1, 15));
          base_addr = 8'($urandom);
          mode = ~m;
        end
      end
      prev_in = in_pipe_en;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 0, 1);
    #1;
    check("done_pulse_len", done, 0);
    if (rdy < 0) check("stall_cycles", stall, 3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_valid"}, win_valid, 0);
    check({tag, "_last"}, win_last, 0);
    check({tag, "_addr"}, win_addr, 32'hFFFF_FFFF);
    check({tag, "_lv"}, lane_valid, 0);
    check({tag, "_max_avg"}, max_avg, 1);
    check({tag, "_in_pipe"}, in_pipe_en, 0);
    check({tag, "_out_pipe"}, out_pipe_en, 0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4, 1, 0, 1, 100, 0, 4};
    tbl[1] = '{3, 1, 0, 0, 100, 0, 4};
    tbl[2] = '{2, 3, 4, 1, 100, 0, 3};
    tbl[3] = '{1, 2, 0, 1, 100, 1, 0};
    tbl[4] = '{4, 0, 0, 0, 100, 1, 0};
    tbl[5] = '{4, 1, 0, 1, -1, 0, 4};
    tbl[6] = '{15, 2, 200, 0, 70, 0, 128};
    tbl[7] = '{5, 15, 250, 1, 50, 0, 135};
    tbl[8] = '{0, 3, 7, 0, 100, 1, 0};
    tbl[9] = '{7, 3, 100, 1, 80, 0, 48};

    win_ready = 1'b1;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    nrst = 1'b1;

    foreach (tbl[i])
      run_cfg(tbl[i].d, tbl[i].n, tbl[i].b, tbl[i].m,
              tbl[i].rdy, tbl[i].err, tbl[i].nwin, i[0]);

    // Reset during the second window of a dim=3 map
    @(negedge clk);
    dim = 4'd3; num_ch = 4'd1; base_addr = 8'd0;
    mode = 1'b0; win_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("d3_w0_addr", win_addr, 32'h0403_0100);
    check("d3_w0_lv", lane_valid, 4'b1111);
    @(negedge clk);
    #1;
    check("d3_w1_addr", win_addr, 32'hFF05_FF02);
    check("d3_w1_lv", lane_valid, 4'b0101);
    nrst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("no_done_after_rst", done, 0);
    end
    run_cfg(3, 1, 0, 0, 100, 0, 4, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int d  = $urandom_range(0, 15);
      int n  = $urandom_range(0, 4);
      int b  = $urandom_range(0, 255);
      int rd = $urandom_range(30, 100);
      bit ee = (d < 2) || (n == 0);
      int nw = ee ? 0 : ((d + 1) / 2) * ((d + 1) / 2) * n;
      run_cfg(d, n, b, 1'($urandom), rd, ee, nw,
              1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
